// File: rtl/axis_flush_fifo.sv
// Packet-aware AXI-Stream FIFO with registered output, occupancy report and a
// four-phase flush handshake that discards buffered and in-flight packet data.
module axis_flush_fifo #(
    parameter int unsigned C_AXIS_WIDTH       = 64,
    parameter int unsigned C_DEPTH            = 256,
    parameter int unsigned C_AXIS_OCCUP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_AXIS_WIDTH-1:0]       s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0]       m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          flush_req,
    output logic                          flush_ack,
    output logic [C_AXIS_OCCUP_WIDTH-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(C_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DROP,
        ST_ACK
    } state_t;

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [C_AXIS_OCCUP_WIDTH-1:0]   occ_q, occ_d;
    logic                            in_pkt_q, in_pkt_d;
    logic                            out_valid_q, out_valid_d;
    logic [C_AXIS_WIDTH-1:0]         out_data_q, out_data_d;
    logic                            out_last_q, out_last_d;
    logic [C_AXIS_WIDTH:0]           mem_q [C_DEPTH];

    logic push, pop, store, load, ram_empty;

    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN:  s_axis_tready = (occ_q != C_AXIS_OCCUP_WIDTH'(C_DEPTH));
                ST_DROP: s_axis_tready = 1'b1;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    assign push      = s_axis_tvalid && s_axis_tready;
    assign pop       = out_valid_q && m_axis_tready;
    assign store     = push && (state_q == ST_RUN);
    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    // RAM never holds more than C_DEPTH-1 beats while the output register is
    // occupied, so equal pointers always mean the RAM is empty.
    assign load      = !ram_empty && (!out_valid_q || pop);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        in_pkt_d    = in_pkt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (store)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (load) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q][C_AXIS_WIDTH-1:0];
            out_last_d  = mem_q[rd_ptr_q][C_AXIS_WIDTH];
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        if (store && !pop)
            occ_d = occ_q + C_AXIS_OCCUP_WIDTH'(1);
        else if (pop && !store)
            occ_d = occ_q - C_AXIS_OCCUP_WIDTH'(1);
        if (push)
            in_pkt_d = !s_axis_tlast;

        case (state_q)
            ST_RUN: begin
                if (flush_req)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // Output valid drops even without a pop: the DMA relies on this.
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                occ_d       = '0;
                out_valid_d = 1'b0;
                state_d     = in_pkt_q ? ST_DROP : ST_ACK;
            end
            ST_DROP: begin
                if (push && s_axis_tlast)
                    state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!flush_req)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_pkt_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            in_pkt_q    <= in_pkt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store)
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_valid_q;
    assign flush_ack     = (state_q == ST_ACK);
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_axis_flush_fifo.sv
// Directed self-checking bench for axis_flush_fifo (depth 16).
module tb_axis_flush_fifo;

    localparam int unsigned W  = 64;
    localparam int unsigned D  = 16;
    localparam int unsigned OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          flush_req;
    logic          flush_ack;
    logic [OW-1:0] occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_flush_fifo #(
        .C_AXIS_WIDTH      (W),
        .C_DEPTH           (D),
        .C_AXIS_OCCUP_WIDTH(OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .flush_req    (flush_req),
        .flush_ack    (flush_ack),
        .occupancy    (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0; flush_req = 1'b0;
        tick(); tick();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 64'h0) begin n_err++; $display("FAIL reset_mdata: got %h expected 0", m_axis_tdata); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_sready: got %b expected 0", s_axis_tready); end
        n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", flush_ack); end
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL run_sready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_single();
        s_axis_tdata = 64'hA5; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        n_cmp++; if (occupancy !== 16'd1) begin n_err++; $display("FAIL single_occ1: got %0d expected 1", occupancy); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_lat1: got %b expected 0", m_axis_tvalid); end
        tick();
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL single_lat2: got %b expected 1", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 64'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", m_axis_tdata); end
        n_cmp++; if (m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL single_last: got %b expected 1", m_axis_tlast); end
        n_cmp++; if (occupancy !== 16'd1) begin n_err++; $display("FAIL single_occ2: got %0d expected 1", occupancy); end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL single_occ0: got %0d expected 0", occupancy); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_full();
        logic         exp_rdy;
        logic [W-1:0] exp_d;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 64'(100 + i); s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
            #1;
            exp_rdy = (i < 16);
            n_cmp++; if (s_axis_tready !== exp_rdy) begin n_err++; $display("FAIL full_ready[%0d]: got %b expected %b", i, s_axis_tready, exp_rdy); end
            tick();
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (occupancy !== 16'd16) begin n_err++; $display("FAIL full_occ: got %0d expected 16", occupancy); end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        n_cmp++; if (occupancy !== 16'd15) begin n_err++; $display("FAIL full_pop_occ: got %0d expected 15", occupancy); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready: got %b expected 1", s_axis_tready); end
        s_axis_tdata = 64'd200; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        n_cmp++; if (occupancy !== 16'd16) begin n_err++; $display("FAIL refill_occ: got %0d expected 16", occupancy); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL refill_ready: got %b expected 0", s_axis_tready); end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? 64'(101 + k) : 64'd200;
            n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d) begin n_err++; $display("FAIL drain[%0d]: got v=%b d=%0d expected v=1 d=%0d", k, m_axis_tvalid, m_axis_tdata, exp_d); end
            tick();
        end
        m_axis_tready = 1'b0;
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        logic          exp_v;
        logic [OW-1:0] exp_o;
        m_axis_tready = 1'b1;
        for (int c = 0; c <= 1002; c++) begin
            exp_v = (c >= 2 && c <= 1001);
            exp_o = (c == 0 || c == 1002) ? 16'd0 : (c == 1 || c == 1001) ? 16'd1 : 16'd2;
            n_cmp++; if (m_axis_tvalid !== exp_v) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected %b", c, m_axis_tvalid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_axis_tdata !== 64'(c - 2)) begin n_err++; $display("FAIL stream_data[%0d]: got %0d expected %0d", c, m_axis_tdata, c - 2); end
            end
            n_cmp++; if (occupancy !== exp_o) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d expected %0d", c, occupancy, exp_o); end
            s_axis_tvalid = (c < 1000);
            s_axis_tdata  = 64'(c);
            s_axis_tlast  = (c % 8 == 7);
            tick();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_flush_boundary();
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 64'(8'h50 + i); s_axis_tlast = (i == 4); s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (occupancy !== 16'd5) begin n_err++; $display("FAIL fb_occ5: got %0d expected 5", occupancy); end
        flush_req = 1'b1;
        tick();
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL fb_flush_ready: got %b expected 0", s_axis_tready); end
        tick();
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL fb_occ0: got %0d expected 0", occupancy); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL fb_mvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (flush_ack !== 1'b1) begin n_err++; $display("FAIL fb_ack: got %b expected 1", flush_ack); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL fb_ack_ready: got %b expected 0", s_axis_tready); end
        tick();
        n_cmp++; if (flush_ack !== 1'b1) begin n_err++; $display("FAIL fb_ack_hold: got %b expected 1", flush_ack); end
        flush_req = 1'b0;
        tick();
        n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL fb_ack_drop: got %b expected 0", flush_ack); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL fb_run_ready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_flush_midpkt();
        int           got;
        logic [W-1:0] exp_d;
        for (int i = 1; i <= 2; i++) begin
            s_axis_tdata = 64'(i); s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        flush_req = 1'b1;
        tick(); tick();
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL mp_drop_ready: got %b expected 1", s_axis_tready); end
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL mp_occ0: got %0d expected 0", occupancy); end
        for (int i = 3; i <= 6; i++) begin
            n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL mp_early_ack[%0d]: got %b expected 0", i, flush_ack); end
            s_axis_tdata = 64'(i); s_axis_tlast = (i == 6); s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        n_cmp++; if (flush_ack !== 1'b1) begin n_err++; $display("FAIL mp_ack: got %b expected 1", flush_ack); end
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL mp_discard_occ: got %0d expected 0", occupancy); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mp_mvalid: got %b expected 0", m_axis_tvalid); end
        flush_req = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_axis_tvalid === 1'b1) begin
                exp_d = 64'(8'h70 + got);
                n_cmp++; if (m_axis_tdata !== exp_d || m_axis_tlast !== (got == 2)) begin n_err++; $display("FAIL mp_next[%0d]: got d=%h l=%b expected d=%h l=%b", got, m_axis_tdata, m_axis_tlast, exp_d, got == 2); end
                got++;
            end
            s_axis_tvalid = (c < 3); s_axis_tdata = 64'(8'h70 + c); s_axis_tlast = (c == 2);
            tick();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL mp_next_count: got %0d expected 3", got); end
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL mp_next_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_rst_mid();
        // Enter DROP: the beat pushed on the flush edge is stored then flushed.
        s_axis_tdata = 64'h9; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; flush_req = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        n_cmp++; if (occupancy !== 16'd1) begin n_err++; $display("FAIL rd_sim_occ: got %0d expected 1", occupancy); end
        tick();
        n_cmp++; if (s_axis_tready !== 1'b1 || flush_ack !== 1'b0) begin n_err++; $display("FAIL rd_in_drop: got rdy=%b ack=%b expected rdy=1 ack=0", s_axis_tready, flush_ack); end
        rst = 1'b1; flush_req = 1'b0;
        tick();
        n_cmp++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, flush_ack} !== 4'b0 || m_axis_tdata !== 64'h0 || occupancy !== 16'd0) begin n_err++; $display("FAIL rd_drop_rst: got rdy=%b v=%b l=%b ack=%b d=%h o=%0d expected all 0", s_axis_tready, m_axis_tvalid, m_axis_tlast, flush_ack, m_axis_tdata, occupancy); end
        rst = 1'b0;
        flush_req = 1'b1;
        tick(); tick();
        n_cmp++; if (flush_ack !== 1'b1) begin n_err++; $display("FAIL rd_in_ack: got %b expected 1", flush_ack); end
        rst = 1'b1; flush_req = 1'b0;
        tick();
        n_cmp++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, flush_ack} !== 4'b0 || m_axis_tdata !== 64'h0 || occupancy !== 16'd0) begin n_err++; $display("FAIL rd_ack_rst: got rdy=%b v=%b l=%b ack=%b d=%h o=%0d expected all 0", s_axis_tready, m_axis_tvalid, m_axis_tlast, flush_ack, m_axis_tdata, occupancy); end
        rst = 1'b0;
        s_axis_tdata = 64'h1234; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1234 || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL rd_after: got v=%b d=%h l=%b expected v=1 d=1234 l=1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        n_cmp++; if (occupancy !== 16'd0) begin n_err++; $display("FAIL rd_after_occ: got %0d expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_flush_boundary();
        test_flush_midpkt();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
